inverse_fib: RTL and testbench
==============================

# inverse_fib

Iterative inverse-Fibonacci search unit, the inverse of the team's iterative Fibonacci generator. It takes an 11-bit value and finds the Fibonacci index k with F(k) == value. If no such k exists, it returns the largest k with F(k) <= value. It uses the same start/ready handshake as the generator, so that feeding `index` back to the generator's `n` input reproduces `value` whenever `is_fib` is 1.

## Interface
- No parameters; widths fixed (value 11 bits, index 4 bits, F(0)..F(15)).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only while `ready` = 1.
- `value`  in  11  value to search; captured on the accepting edge, ignored otherwise.
- `ready`  out  1  1 = idle and results valid; 0 = search in progress.
- `index`  out  4  result index.
- `is_fib`  out  1  1 = F(index) == captured value.
- `range_err`  out  1  1 = captured value >= F(16) (987); the index does not fit in 4 bits.

## Operation
- States:
  - IDLE: `ready` = 1.
  - SEARCH: `ready` = 0.
- Registers: `v` (11 bit), `a` = F(k), `b` = F(k+1) (11 bit each), `k` (4 bit).
- IDLE: on an edge with `start` = 1:
  - v <= value, a <= 0, b <= 1, k <= 0.
  - Go to SEARCH.
  - `ready` <= 0.
  - `index`/`is_fib`/`range_err` hold their previous values.
- SEARCH, each edge, first matching rule wins:
  1. a == v: index <= k, is_fib <= 1, range_err <= 0; go to IDLE.
  2. b > v: index <= k, is_fib <= 0, range_err <= 0; go to IDLE.
  3. k == 15 (a = 610, b = 987 <= v): index <= 15, is_fib <= 0, range_err <= 1; go to IDLE.
  4. Otherwise: a <= b, b <= a + b, k <= k + 1.
- Arithmetic: a + b never exceeds 987 under these rules, so 11-bit addition without overflow suffices. No wrap of k is possible, since rule 3 stops at 15.
- Value 1 matches F(1) and F(2); rule order returns the smallest, index 1.
- Value 0 returns index 0, is_fib 1.
- `start` while in SEARCH is ignored; the in-flight search is unaffected and no request is queued.
- `value` changes during SEARCH have no effect.
- The three result outputs update together on the same edge that raises `ready`.

## Timing
- Reset (async assert, any state):
  - state = IDLE, `ready` = 1.
  - `index` = 0, `is_fib` = 0, `range_err` = 0.
  - Internal a/b/k/v cleared.
- Reset asserted mid-search aborts the search; no partial result is written.
- Deassertion is released to the next clock edge.
- Latency: with `start` sampled at edge E0, `ready` and the results are valid after edge E0 + K + 1.
  - K = final k; 1 to 16 cycles.
  - Value 0: 1 cycle. Value 34: 10 cycles. Range error: 16 cycles.
- `ready` falls after E0 and stays low exactly K + 1 cycles.
- `start` may be held high. A new search starts on the first edge with `ready` = 1 and `start` = 1, including the edge right after completion, giving back-to-back operation with no idle cycle.

## Test plan
- Reset: assert `rst_n` = 0 mid-search (value 600, after 5 cycles) -> `ready` = 1, index/is_fib/range_err = 0 immediately, without a clock edge. Then start value 0 -> index 0, is_fib 1, `ready` high 1 cycle after start.
- Exact hits:
  - value 34 -> index 9, is_fib 1, ready after 10 cycles.
  - value 1 -> index 1, is_fib 1.
  - value 610 -> index 15, is_fib 1, ready after 16 cycles.
- Non-Fibonacci values:
  - value 100 -> index 11, is_fib 0, range_err 0, ready after 12 cycles.
  - value 986 -> index 15, is_fib 0, range_err 0.
- Range errors:
  - value 987 -> index 15, is_fib 0, range_err 1, ready after 16 cycles.
  - value 2047 -> same result.
- Busy handling: start value 55, then pulse `start` with value 3 at cycle 4 -> only the first search runs: index 10, is_fib 1 after 11 cycles, then `ready` stays 1.
- Back-to-back with `start` held high: values 8 then 13 -> results index 6 then index 7, no idle cycle between. Loopback each result into the Fibonacci generator -> its output equals the original value whenever is_fib = 1.

Source files
------------

// File: rtl/inverse_fib_if.sv
// Start/ready request bus of the inverse-Fibonacci search unit.
// The requester uses the master view, the search engine the slave view.
interface inverse_fib_if;
    logic        start;
    logic [10:0] value;
    logic        ready;
    logic [3:0]  index;
    logic        is_fib;
    logic        range_err;

    modport master (
        output start,
        output value,
        input  ready,
        input  index,
        input  is_fib,
        input  range_err
    );

    modport slave (
        input  start,
        input  value,
        output ready,
        output index,
        output is_fib,
        output range_err
    );
endinterface

// File: rtl/inverse_fib.sv
// Iterative inverse-Fibonacci search: walks F(k), F(k+1) upward until it
// hits or passes the captured value, then reports k with hit/overflow flags.
module inverse_fib (
    input  logic          clk,
    input  logic          rst_n,
    inverse_fib_if.slave  bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] v_q, v_d;
    logic [10:0] a_q, a_d;
    logic [10:0] b_q, b_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  index_q, index_d;
    logic        is_fib_q, is_fib_d;
    logic        range_err_q, range_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            index_q     <= '0;
            is_fib_q    <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            index_q     <= index_d;
            is_fib_q    <= is_fib_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        index_d     = index_q;
        is_fib_d    = is_fib_q;
        range_err_d = range_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    v_d     = bus.value;
                    a_d     = 11'd0;
                    b_d     = 11'd1;
                    k_d     = 4'd0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // Exact hit is tested first so value 1 resolves to F(1), not F(2).
                if (a_q == v_q) begin
                    index_d     = k_q;
                    is_fib_d    = 1'b1;
                    range_err_d = 1'b0;
                    state_d     = IDLE;
                end else if (b_q > v_q) begin
                    index_d     = k_q;
                    is_fib_d    = 1'b0;
                    range_err_d = 1'b0;
                    state_d     = IDLE;
                end else if (k_q == 4'd15) begin
                    index_d     = 4'd15;
                    is_fib_d    = 1'b0;
                    range_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // Largest sum reached is 377 + 610 = 987, so 11 bits never wrap.
                    a_d = b_q;
                    b_d = a_q + b_q;
                    k_d = k_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.index     = index_q;
    assign bus.is_fib    = is_fib_q;
    assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_inverse_fib.sv
// Scoreboard bench for inverse_fib: requests push expected results, the
// monitor pops them when ready rises and checks result, latency and loopback.
module tb_inverse_fib;
    typedef struct {
        int value;
        int index;
        int is_fib;
        int range_err;
        int lat;
    } exp_t;

    logic clk;
    logic rst_n;
    inverse_fib_if bus_if ();

    inverse_fib dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   in_flight;
    int   cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fib(input int n);
        int x = 0;
        int y = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp_t model(input int v);
        exp_t r;
        int   f[17];
        int   k;
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i < 17; i++) f[i] = f[i-1] + f[i-2];
        r.value = v;
        if (v >= f[16]) begin
            r.index = 15; r.is_fib = 0; r.range_err = 1; r.lat = 16;
        end else begin
            k = -1;
            for (int i = 0; i < 16; i++) if (f[i] == v && k < 0) k = i;
            if (k >= 0) begin
                r.is_fib = 1;
            end else begin
                r.is_fib = 0;
                for (int i = 0; i < 16; i++) if (f[i] <= v) k = i;
            end
            r.index = k; r.range_err = 0; r.lat = k + 1;
        end
        return r;
    endfunction

    // Monitor: counts busy cycles after an accepted start, scores the result.
    initial begin
        exp_t e;
        in_flight = 1'b0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_flight = 1'b0;
                continue;
            end
            if (in_flight) begin
                if (!bus_if.ready) begin
                    cnt++;
                end else begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("txn value=%0d index=%0d is_fib=%0d range_err=%0d cycles=%0d",
                                 e.value, bus_if.index, bus_if.is_fib, bus_if.range_err, cnt);
                        chk($sformatf("index_v%0d", e.value), int'(bus_if.index), e.index);
                        chk($sformatf("is_fib_v%0d", e.value), int'(bus_if.is_fib), e.is_fib);
                        chk($sformatf("range_err_v%0d", e.value), int'(bus_if.range_err), e.range_err);
                        chk($sformatf("latency_v%0d", e.value), cnt, e.lat);
                        if (bus_if.is_fib)
                            chk($sformatf("loopback_v%0d", e.value), fib(int'(bus_if.index)), e.value);
                    end
                    in_flight = 1'b0;
                end
            end
            if (!in_flight && bus_if.ready && bus_if.start) begin
                in_flight = 1'b1;
                cnt       = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.ready) break;
        end
        if (i == 40) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic issue(input int v);
        wait_ready();
        bus_if.start = 1'b1;
        bus_if.value = 11'(v);
        sb.push_back(model(v));
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.value = 11'($urandom_range(0, 2047));
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && bus_if.ready) break;
        end
        if (i == 40) begin
            chk("wait_idle_timeout", 0, 1);
            sb.delete();
            do_reset();
        end
    endtask

    initial begin
        int vals[7] = '{0, 1, 610, 100, 986, 987, 2047};

        bus_if.start = 1'b0;
        bus_if.value = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(bus_if.ready), 1);
        chk("rst_index", int'(bus_if.index), 0);
        chk("rst_is_fib", int'(bus_if.is_fib), 0);
        chk("rst_range_err", int'(bus_if.range_err), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(34);
        wait_idle();

        // Reset mid-search must clear results immediately, without a clock edge.
        issue(600);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(bus_if.ready), 1);
        chk("midrst_index", int'(bus_if.index), 0);
        chk("midrst_is_fib", int'(bus_if.is_fib), 0);
        chk("midrst_range_err", int'(bus_if.range_err), 0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vals[i]) begin
            issue(vals[i]);
            wait_idle();
        end

        // Start pulse during a search must be ignored.
        issue(55);
        repeat (2) @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        bus_if.value = 11'd3;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        wait_idle();
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("busy_ready_stays", int'(bus_if.ready), 1);
        end
        chk("busy_index_kept", int'(bus_if.index), 10);

        // Back-to-back with start held high.
        wait_ready();
        bus_if.start = 1'b1;
        bus_if.value = 11'd8;
        sb.push_back(model(8));
        @(posedge clk);
        #1;
        bus_if.value = 11'd13;
        sb.push_back(model(13));
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (sb.size() <= 1) break;
            end
            if (i == 40) chk("b2b_timeout", 0, 1);
        end
        bus_if.start = 1'b0;
        chk("b2b_no_idle", int'(bus_if.ready), 0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
